// File: rtl/mem_access_unit.sv
// Load/store bridge between the single-cycle core and a variable-latency data memory.
// Runs one req/ack transaction per memory instruction and stalls the core until it retires.
module mem_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_MemRead,
   input  logic                  i_MemWrite,
   input  logic [ADDR_WIDTH-1:0] i_Address,
   input  logic [DATA_WIDTH-1:0] i_WriteData,
   output logic [DATA_WIDTH-1:0] o_ReadData,
   output logic                  o_Stall,
   output logic                  o_Error,
   output logic                  o_ErrorSticky,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic                  i_mem_ack,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             request;
   logic             misaligned;

   assign request    = i_MemRead | i_MemWrite;
   assign misaligned = |i_Address[1:0];

   // NOTE: continuous assign from state and inputs, so no latch; gated by rst so every output is 0 in reset.
   assign o_Stall = rst & ((state == IDLE) ? request : (state == ACCESS));

   // NOTE: sequential state uses non-blocking assignments only, and every register gets a reset value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         count         <= '0;
         o_ReadData    <= '0;
         o_Error       <= 1'b0;
         o_ErrorSticky <= 1'b0;
         o_mem_req     <= 1'b0;
         o_mem_we      <= 1'b0;
         o_mem_addr    <= '0;
         o_mem_wdata   <= '0;
      end else begin
         o_Error <= 1'b0;
         case (state)
            IDLE: begin
               if (request) begin
                  o_mem_we    <= i_MemWrite;
                  o_mem_addr  <= {i_Address[ADDR_WIDTH-1:2], 2'b00};
                  o_mem_wdata <= i_WriteData;
                  if (misaligned) begin
                     o_Error       <= 1'b1;
                     o_ErrorSticky <= 1'b1;
                     o_ReadData    <= '0;
                     state         <= DONE;
                  end else begin
                     o_mem_req <= 1'b1;
                     count     <= '0;
                     state     <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               // An ack on the last allowed cycle still completes the access.
               if (i_mem_ack) begin
                  o_mem_req <= 1'b0;
                  if (!o_mem_we) o_ReadData <= i_mem_rdata;
                  state <= DONE;
               end else if (count == CNT_LAST) begin
                  o_mem_req     <= 1'b0;
                  o_Error       <= 1'b1;
                  o_ErrorSticky <= 1'b1;
                  o_ReadData    <= '0;
                  state         <= DONE;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
